free_list_ctrl: RTL and testbench
=================================

// Module: free_list_ctrl
// PURPOSE
//  Controller for the physical-register free list that feeds the rename stage.
//  - Initialises the list with physical regs 32..63 after reset.
//  - Hands out two pregs per allocation; reclaims up to two old_rd pregs per cycle on commit.
//  - Takes one head-pointer checkpoint on save_state_i and rolls back to it on restore_i.
//  - Sits between rename (allocation side) and commit/ROB (reclaim side).
// PARAMETERS
//  NumPhysRegs  64  physical register file size; preg index width = $clog2(NumPhysRegs)
//  NumArchRegs  32  architectural regs; list depth = NumPhysRegs-NumArchRegs (32)
// PORTS
//  clk_i           in   1  clock
//  rst_i           in   1  synchronous, active-high reset
//  alloc_req_i     in   1  rename consumes two pregs this cycle (ignored unless alloc_ready_o)
//  alloc_ready_o   out  1  init done, >=2 entries free, no restore this cycle
//  alloc_preg_0_o  out  6  preg at head (combinational, valid while alloc_ready_o)
//  alloc_preg_1_o  out  6  preg at head+1
//  free_valid_i    in   2  per-slot reclaim valid from commit
//  free_preg_0_i   in   6  preg returned by slot 0
//  free_preg_1_i   in   6  preg returned by slot 1
//  save_state_i    in   1  snapshot head pointer (branch dispatched)
//  restore_i       in   1  roll head back to snapshot (mispredict)
//  init_done_o     out  1  list initialised
//  free_count_o    out  6  entries currently free, 0..32
//  overflow_o      out  1  sticky: reclaim attempted with list full
// BEHAVIOUR
//  - Pointers: head_q and tail_q are 6 bits: 5-bit index plus wrap bit.
//    free_count = tail_q - head_q (mod 64). Empty: equal; full: index equal, wrap bits differ.
//  - Reset values: state=StInit, head=0, tail=0, init ctr=0, ckpt_valid=0;
//    alloc_ready_o=0, init_done_o=0, free_count_o=0, overflow_o=0.
//  - FSM StInit: each cycle write {ctr+33, ctr+32} at tail, tail+=2, ctr+=2.
//    After 16 cycles (ctr==30 written) go to StRun; tail=32 (full), free_count=32.
//    In StInit, alloc_req_i, free_valid_i, save_state_i and restore_i are ignored.
//  - StRun alloc: alloc_req_i & alloc_ready_o -> head += 2 next cycle; outputs update 0-cycle after.
//  - Reclaim in StRun:
//    11 -> write preg0 at tail, preg1 at tail+1, tail+=2.
//    10 or 01 -> write the valid preg at tail, tail+=1. Slot-1-only is compacted, no hole.
//    Reclaims that would make free_count exceed 32 are dropped and set overflow_o.
//  - save_state_i: ckpt_head <= head_d (includes same-cycle alloc); ckpt_valid <= 1.
//    A new save overwrites the old snapshot.
//  - restore_i with ckpt_valid: head <= ckpt_head. Same-cycle alloc is suppressed
//    (alloc_ready_o=0 when restore_i). Same-cycle reclaim still applies to tail. ckpt_valid cleared.
//  - restore_i without ckpt_valid: no effect on head.
//  - save_state_i & restore_i together: restore wins, save ignored.
//  - Wrap-around: index arithmetic mod 32; wrap bit toggles on index overflow.
//  - Reset mid-StInit or mid-StRun: all state returns to reset values and init restarts.
// STRUCTURE
//  - decode_pkg gains: FREE_LIST_DEPTH, PREG_W and the fl_state_e {StInit, StRun} typedef.
//  - Sub-module free_list_ram holds the storage:
//    32x6 regs, 2 async read ports (head, head+1), 2 sync write ports (tail, tail+1).
//  - Pointer, checkpoint and FSM logic live in free_list_ctrl.
// TESTING
//  - Init: release rst_i -> init_done_o=1 after 16 cycles; free_count_o=32;
//    alloc_preg_0/1_o = 32/33.
//  - Drain: 16 consecutive alloc_req_i -> pregs 32..63 in order;
//    free_count_o=0; alloc_ready_o=0 at free_count 0 and 1.
//  - Reclaim: with 0 free, free_valid_i=01 preg 40 then 11 pregs 41,42
//    -> free_count 3; next alloc gives 40,41.
//  - Checkpoint: from head=4, save then 3 allocs, then restore
//    -> head back to 4; next alloc returns the same pregs as after the save.
//  - Collision: restore + alloc_req_i + free_valid_i=11 in one cycle
//    -> alloc suppressed, head=ckpt, tail+=2.
//  - Overflow/reset: free with list full -> overflow_o=1, count stays 32;
//    rst_i mid-init -> restart, init_done_o after 16 cycles.

Source files
------------

// File: rtl/free_list_ctrl_pkg.sv
// Shared types and sizing for the physical-register free list.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package free_list_ctrl_pkg;

    localparam int NUM_PHYS_REGS   = 64;
    localparam int NUM_ARCH_REGS   = 32;
    localparam int FREE_LIST_DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS;
    localparam int PREG_W          = $clog2(NUM_PHYS_REGS);
    localparam int IDX_W           = $clog2(FREE_LIST_DEPTH);
    // Pointer carries one extra wrap bit above the list index.
    localparam int PTR_W           = IDX_W + 1;

    typedef logic [PREG_W-1:0] preg_t;
    typedef logic [PTR_W-1:0]  ptr_t;
    typedef logic [IDX_W-1:0]  idx_t;

    typedef enum logic {
        StInit = 1'b0,
        StRun  = 1'b1
    } fl_state_e;

endpackage

// File: rtl/free_list_ram.sv
// Free-list storage: 32 entries of preg indices, 2 async read and 2 sync write ports.
// Latency: reads combinational, writes visible the cycle after the write edge.
// Backpressure: none; callers never write both ports to the same index.
module free_list_ram
    import free_list_ctrl_pkg::*;
(
    input  logic  clk_i,
    input  logic  we_0_i,
    input  idx_t  waddr_0_i,
    input  preg_t wdata_0_i,
    input  logic  we_1_i,
    input  idx_t  waddr_1_i,
    input  preg_t wdata_1_i,
    input  idx_t  raddr_0_i,
    input  idx_t  raddr_1_i,
    output preg_t rdata_0_o,
    output preg_t rdata_1_o
);

    preg_t mem [FREE_LIST_DEPTH];

    // Two independent write ports; the controller always targets tail and tail+1.
    always_ff @(posedge clk_i) begin
        if (we_0_i) mem[waddr_0_i] <= wdata_0_i;
        if (we_1_i) mem[waddr_1_i] <= wdata_1_i;
    end

    assign rdata_0_o = mem[raddr_0_i];
    assign rdata_1_o = mem[raddr_1_i];

endmodule

// File: rtl/free_list_ctrl.sv
// Free-list controller: init fill, paired allocation, dual reclaim, one head checkpoint.
// Latency: alloc outputs combinational from head; pointer updates land next cycle.
// Backpressure: alloc_ready_o low during init, restore, or with fewer than 2 free entries.
module free_list_ctrl
    import free_list_ctrl_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        alloc_req_i,
    output logic        alloc_ready_o,
    output logic [5:0]  alloc_preg_0_o,
    output logic [5:0]  alloc_preg_1_o,
    input  logic [1:0]  free_valid_i,
    input  logic [5:0]  free_preg_0_i,
    input  logic [5:0]  free_preg_1_i,
    input  logic        save_state_i,
    input  logic        restore_i,
    output logic        init_done_o,
    output logic [5:0]  free_count_o,
    output logic        overflow_o
);

    fl_state_e    state_q, state_d;
    ptr_t         head_q, head_d;
    ptr_t         tail_q, tail_d;
    idx_t         ctr_q, ctr_d;
    ptr_t         ckpt_head_q, ckpt_head_d;
    logic         ckpt_valid_q, ckpt_valid_d;
    logic         overflow_q, overflow_d;

    logic         alloc_ready;
    logic         alloc_fire;
    ptr_t         free_count;
    logic [1:0]   n_free;
    ptr_t         room;
    logic [PTR_W:0] room_after;

    logic         we_0, we_1;
    preg_t        wdata_0, wdata_1;

    assign free_count    = tail_q - head_q;
    assign alloc_ready   = (state_q == StRun) && (free_count >= ptr_t'(2)) && !restore_i;
    assign alloc_fire    = alloc_req_i && alloc_ready;
    assign n_free        = {1'b0, free_valid_i[0]} + {1'b0, free_valid_i[1]};

    // Next-state, pointer, checkpoint and write-port control.
    always_comb begin
        state_d      = state_q;
        head_d       = head_q;
        tail_d       = tail_q;
        ctr_d        = ctr_q;
        ckpt_head_d  = ckpt_head_q;
        ckpt_valid_d = ckpt_valid_q;
        overflow_d   = overflow_q;
        we_0         = 1'b0;
        we_1         = 1'b0;
        wdata_0      = free_preg_0_i;
        wdata_1      = free_preg_1_i;
        room         = '0;
        room_after   = '0;

        case (state_q)
            StInit: begin
                // ctr is even, so ctr+32 / ctr+33 are just the top bit set and bit 0 forced.
                we_0    = 1'b1;
                we_1    = 1'b1;
                wdata_0 = {1'b1, ctr_q};
                wdata_1 = {1'b1, ctr_q[IDX_W-1:1], 1'b1};
                tail_d  = tail_q + ptr_t'(2);
                ctr_d   = ctr_q + idx_t'(2);
                if (ctr_q == idx_t'(FREE_LIST_DEPTH - 2)) begin
                    state_d = StRun;
                end
            end

            StRun: begin
                if (restore_i) begin
                    // Restore beats both same-cycle alloc (already masked) and save.
                    if (ckpt_valid_q) begin
                        head_d       = ckpt_head_q;
                        ckpt_valid_d = 1'b0;
                    end
                end else begin
                    if (alloc_fire) begin
                        head_d = head_q + ptr_t'(2);
                    end
                    if (save_state_i) begin
                        ckpt_head_d  = head_d;
                        ckpt_valid_d = 1'b1;
                    end
                end

                // Occupancy is judged against the post-alloc/post-restore head.
                room       = tail_q - head_d;
                room_after = {1'b0, room} + {{(PTR_W-1){1'b0}}, n_free};
                if (n_free != 2'd0) begin
                    if (room_after > (PTR_W+1)'(FREE_LIST_DEPTH)) begin
                        overflow_d = 1'b1;
                    end else begin
                        // A lone slot-1 return is packed into the tail slot.
                        we_0    = 1'b1;
                        we_1    = (n_free == 2'd2);
                        wdata_0 = free_valid_i[0] ? free_preg_0_i : free_preg_1_i;
                        wdata_1 = free_preg_1_i;
                        tail_d  = tail_q + ptr_t'(n_free);
                    end
                end
            end

            default: state_d = StInit;
        endcase
    end

    // State registers with synchronous reset; reset restarts the init fill.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StInit;
            head_q       <= '0;
            tail_q       <= '0;
            ctr_q        <= '0;
            ckpt_head_q  <= '0;
            ckpt_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            ctr_q        <= ctr_d;
            ckpt_head_q  <= ckpt_head_d;
            ckpt_valid_q <= ckpt_valid_d;
            overflow_q   <= overflow_d;
        end
    end

    free_list_ram u_ram (
        .clk_i     (clk_i),
        .we_0_i    (we_0),
        .waddr_0_i (tail_q[IDX_W-1:0]),
        .wdata_0_i (wdata_0),
        .we_1_i    (we_1),
        .waddr_1_i (tail_q[IDX_W-1:0] + idx_t'(1)),
        .wdata_1_i (wdata_1),
        .raddr_0_i (head_q[IDX_W-1:0]),
        .raddr_1_i (head_q[IDX_W-1:0] + idx_t'(1)),
        .rdata_0_o (alloc_preg_0_o),
        .rdata_1_o (alloc_preg_1_o)
    );

    assign alloc_ready_o = alloc_ready;
    assign init_done_o   = (state_q == StRun);
    assign free_count_o  = free_count;
    assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_free_list_ctrl.sv
// Directed bench for free_list_ctrl: init, drain, reclaim, checkpoint, collision, overflow, reset.
// Latency: inputs driven 1ns after the rising edge, outputs sampled before the next edge.
// Backpressure: alloc requests are only issued where the expected state says ready.
module tb_free_list_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       alloc_req_i;
    logic       alloc_ready_o;
    logic [5:0] alloc_preg_0_o;
    logic [5:0] alloc_preg_1_o;
    logic [1:0] free_valid_i;
    logic [5:0] free_preg_0_i;
    logic [5:0] free_preg_1_i;
    logic       save_state_i;
    logic       restore_i;
    logic       init_done_o;
    logic [5:0] free_count_o;
    logic       overflow_o;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc;

    always #5 clk_i = ~clk_i;

    free_list_ctrl dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .alloc_req_i    (alloc_req_i),
        .alloc_ready_o  (alloc_ready_o),
        .alloc_preg_0_o (alloc_preg_0_o),
        .alloc_preg_1_o (alloc_preg_1_o),
        .free_valid_i   (free_valid_i),
        .free_preg_0_i  (free_preg_0_i),
        .free_preg_1_i  (free_preg_1_i),
        .save_state_i   (save_state_i),
        .restore_i      (restore_i),
        .init_done_o    (init_done_o),
        .free_count_o   (free_count_o),
        .overflow_o     (overflow_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_alloc();
        alloc_req_i = 1'b1;
        step();
        alloc_req_i = 1'b0;
    endtask

    task automatic do_free(input logic [1:0] v, input logic [5:0] p0, input logic [5:0] p1);
        free_valid_i  = v;
        free_preg_0_i = p0;
        free_preg_1_i = p1;
        step();
        free_valid_i  = 2'b00;
    endtask

    task automatic wait_init(output int cycles);
        cycles = 0;
        while (!init_done_o && cycles < 40) begin
            step();
            cycles++;
        end
    endtask

    initial begin
        rst_i         = 1'b1;
        alloc_req_i   = 1'b0;
        free_valid_i  = 2'b00;
        free_preg_0_i = '0;
        free_preg_1_i = '0;
        save_state_i  = 1'b0;
        restore_i     = 1'b0;
        repeat (3) step();

        check_eq("rst_init_done", init_done_o, 0);
        check_eq("rst_ready", alloc_ready_o, 0);
        check_eq("rst_count", free_count_o, 0);
        check_eq("rst_overflow", overflow_o, 0);

        // Init fill; requests during init must be ignored.
        rst_i        = 1'b0;
        alloc_req_i  = 1'b1;
        free_valid_i = 2'b11;
        restore_i    = 1'b1;
        step();
        alloc_req_i  = 1'b0;
        free_valid_i = 2'b00;
        restore_i    = 1'b0;
        wait_init(cyc);
        check_eq("init_cycles", cyc + 1, 16);
        check_eq("init_count", free_count_o, 32);
        check_eq("init_preg0", alloc_preg_0_o, 32);
        check_eq("init_preg1", alloc_preg_1_o, 33);
        check_eq("init_ready", alloc_ready_o, 1);

        // Drain: pairs come out in order 32..63.
        for (int i = 0; i < 16; i++) begin
            check_eq("drain_count", free_count_o, 32 - 2 * i);
            check_eq("drain_ready", alloc_ready_o, 1);
            check_eq("drain_preg0", alloc_preg_0_o, 32 + 2 * i);
            check_eq("drain_preg1", alloc_preg_1_o, 33 + 2 * i);
            do_alloc();
        end
        check_eq("empty_count", free_count_o, 0);
        check_eq("empty_ready", alloc_ready_o, 0);

        // Reclaim from empty.
        do_free(2'b01, 6'd40, 6'd0);
        check_eq("one_free_count", free_count_o, 1);
        check_eq("one_free_ready", alloc_ready_o, 0);
        do_free(2'b11, 6'd41, 6'd42);
        check_eq("reclaim_count", free_count_o, 3);
        check_eq("reclaim_ready", alloc_ready_o, 1);
        check_eq("reclaim_preg0", alloc_preg_0_o, 40);
        check_eq("reclaim_preg1", alloc_preg_1_o, 41);
        do_alloc();
        check_eq("post_alloc_count", free_count_o, 1);

        // Slot-1-only reclaim is compacted (43 lands right after 42).
        do_free(2'b10, 6'd0, 6'd43);
        do_free(2'b11, 6'd44, 6'd45);
        do_free(2'b11, 6'd46, 6'd47);
        check_eq("compact_count", free_count_o, 6);
        check_eq("compact_preg0", alloc_preg_0_o, 42);
        check_eq("compact_preg1", alloc_preg_1_o, 43);
        do_alloc();
        do_free(2'b11, 6'd48, 6'd49);
        do_free(2'b11, 6'd50, 6'd51);
        check_eq("pre_save_count", free_count_o, 8);
        check_eq("pre_save_preg0", alloc_preg_0_o, 44);

        // Checkpoint at head index 4, three allocs, then restore.
        save_state_i = 1'b1;
        step();
        save_state_i = 1'b0;
        check_eq("save_count", free_count_o, 8);
        repeat (3) do_alloc();
        check_eq("spec_count", free_count_o, 2);
        check_eq("spec_preg0", alloc_preg_0_o, 50);
        restore_i = 1'b1;
        #1;
        check_eq("restore_ready", alloc_ready_o, 0);
        step();
        restore_i = 1'b0;
        check_eq("restore_count", free_count_o, 8);
        check_eq("restore_preg0", alloc_preg_0_o, 44);
        check_eq("restore_preg1", alloc_preg_1_o, 45);

        // Save with same-cycle alloc snapshots the advanced head.
        save_state_i = 1'b1;
        alloc_req_i  = 1'b1;
        step();
        save_state_i = 1'b0;
        alloc_req_i  = 1'b0;
        check_eq("save_alloc_count", free_count_o, 6);
        check_eq("save_alloc_preg0", alloc_preg_0_o, 46);
        do_alloc();
        check_eq("pre_coll_preg0", alloc_preg_0_o, 48);

        // Collision: restore + alloc + dual reclaim.
        restore_i     = 1'b1;
        alloc_req_i   = 1'b1;
        free_valid_i  = 2'b11;
        free_preg_0_i = 6'd52;
        free_preg_1_i = 6'd53;
        step();
        restore_i    = 1'b0;
        alloc_req_i  = 1'b0;
        free_valid_i = 2'b00;
        check_eq("coll_count", free_count_o, 8);
        check_eq("coll_preg0", alloc_preg_0_o, 46);
        check_eq("coll_preg1", alloc_preg_1_o, 47);

        // Restore with no live checkpoint leaves head alone.
        restore_i = 1'b1;
        step();
        restore_i = 1'b0;
        check_eq("stale_restore_count", free_count_o, 8);
        check_eq("stale_restore_preg0", alloc_preg_0_o, 46);

        // Fill to full, then one more reclaim overflows and is dropped.
        for (int i = 0; i < 12; i++) begin
            do_free(2'b11, 6'(2 * i), 6'(2 * i + 1));
        end
        check_eq("full_count", free_count_o, 32);
        check_eq("full_overflow", overflow_o, 0);
        do_free(2'b01, 6'd61, 6'd0);
        check_eq("ovf_flag", overflow_o, 1);
        check_eq("ovf_count", free_count_o, 32);
        check_eq("ovf_head_intact", alloc_preg_0_o, 46);

        // Reset mid-run, then again mid-init.
        rst_i = 1'b1;
        step();
        check_eq("rerst_overflow", overflow_o, 0);
        check_eq("rerst_count", free_count_o, 0);
        check_eq("rerst_init_done", init_done_o, 0);
        rst_i = 1'b0;
        repeat (5) step();
        check_eq("mid_init_done", init_done_o, 0);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        wait_init(cyc);
        check_eq("reinit_cycles", cyc, 16);
        check_eq("reinit_count", free_count_o, 32);
        check_eq("reinit_preg0", alloc_preg_0_o, 32);
        check_eq("reinit_preg1", alloc_preg_1_o, 33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
